// File: rtl/huff_sym_histogram.sv
// huff_sym_histogram: per-block symbol frequency counter with a sequential two-minimum scan
module huff_sym_histogram #(
   parameter int NUM_SYM   = 10,
   parameter int SYM_W     = 4,
   parameter int CNT_W     = 9,
   parameter int BLOCK_LEN = 256,
   parameter int IDX_W     = $clog2(NUM_SYM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SYM_W-1:0] data_in,
   input  logic             data_valid,
   output logic             busy,
   output logic             count_done,
   output logic             scan_done,
   output logic             min_valid,
   output logic [IDX_W-1:0] min1_idx,
   output logic [IDX_W-1:0] min2_idx,
   output logic             min1_ok,
   output logic             min2_ok,
   output logic [15:0]      oor_cnt,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [CNT_W-1:0] rd_data
);
   typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;
   // minima carry an extra top bit so "empty" compares above every real count
   localparam logic [CNT_W:0] EMPTY = {1'b1, {CNT_W{1'b0}}};
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q [NUM_SYM];
   logic [15:0]      oor_q, beat_q;
   logic [IDX_W-1:0] idx_q, m1i_q, m2i_q;
   logic [CNT_W:0]   m1v_q, m2v_q;
   logic [CNT_W-1:0] rd_q, cand;
   logic             scan_done_q, in_range, last_beat;
   logic [IDX_W-1:0] sym;
   always_comb begin
      sym       = IDX_W'(data_in);
      in_range  = 32'(data_in) < NUM_SYM;
      last_beat = state_q == COUNT && data_valid && beat_q == 16'(BLOCK_LEN - 1);
      cand      = cnt_q[idx_q];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int k = 0; k < NUM_SYM; k++) cnt_q[k] <= '0;
         oor_q       <= '0;
         beat_q      <= '0;
         idx_q       <= '0;
         m1i_q       <= '0;
         m2i_q       <= '0;
         m1v_q       <= EMPTY;
         m2v_q       <= EMPTY;
         rd_q        <= '0;
         scan_done_q <= 1'b0;
      end else begin
         rd_q        <= (32'(rd_addr) < NUM_SYM) ? cnt_q[rd_addr] : '0;
         scan_done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: if (start) begin
               for (int k = 0; k < NUM_SYM; k++) cnt_q[k] <= '0;
               oor_q   <= '0;
               beat_q  <= '0;
               idx_q   <= '0;
               m1i_q   <= '0;
               m2i_q   <= '0;
               m1v_q   <= EMPTY;
               m2v_q   <= EMPTY;
               state_q <= COUNT;
            end
            COUNT: if (data_valid) begin
               beat_q <= beat_q + 16'd1;
               if (in_range) begin
                  if (cnt_q[sym] != '1) cnt_q[sym] <= cnt_q[sym] + CNT_W'(1);
               end else if (oor_q != '1) oor_q <= oor_q + 16'd1;
               if (last_beat) state_q <= SCAN;
            end
            SCAN: begin
               if (cand != '0) begin
                  if ({1'b0, cand} < m1v_q) begin
                     m2v_q <= m1v_q;
                     m2i_q <= m1i_q;
                     m1v_q <= {1'b0, cand};
                     m1i_q <= idx_q;
                  end else if ({1'b0, cand} < m2v_q) begin
                     m2v_q <= {1'b0, cand};
                     m2i_q <= idx_q;
                  end
               end
               idx_q <= idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(NUM_SYM - 1)) begin
                  state_q     <= DONE;
                  scan_done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy       = state_q == COUNT || state_q == SCAN;
   assign count_done = last_beat;
   assign scan_done  = scan_done_q;
   assign min_valid  = state_q == DONE;
   assign min1_ok    = ~m1v_q[CNT_W];
   assign min2_ok    = ~m2v_q[CNT_W];
   assign min1_idx   = min1_ok ? m1i_q : '0;
   assign min2_idx   = min2_ok ? m2i_q : '0;
   assign oor_cnt    = oor_q;
   assign rd_data    = rd_q;
endmodule

// File: tb/tb_huff_sym_histogram.sv
// tb_huff_sym_histogram: randomized block stimulus checked against a frequency/selection model
module tb_huff_sym_histogram;
   localparam int NS = 10;
   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, start_s = 1'b0, data_valid = 1'b0;
   logic [3:0] data_in = '0, rd_addr = '0;
   logic busy, count_done, scan_done, min_valid, min1_ok, min2_ok;
   logic [3:0] min1_idx, min2_idx;
   logic [15:0] oor_cnt;
   logic [8:0] rd_data;
   logic busy_s, count_done_s, scan_done_s, min_valid_s, min1_ok_s, min2_ok_s;
   logic [3:0] min1_idx_s, min2_idx_s;
   logic [15:0] oor_cnt_s;
   logic [3:0] rd_data_s;
   int checks = 0, failures = 0;
   int syms[$];
   int exp_cnt[NS], got_cnt[NS];
   int exp_oor, got_oor, cd_n, cd_at, lat;
   logic [10:0] exp_min, got_min;

   always #5 clk = ~clk;

   huff_sym_histogram u_dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_valid(data_valid),
      .busy(busy), .count_done(count_done), .scan_done(scan_done), .min_valid(min_valid),
      .min1_idx(min1_idx), .min2_idx(min2_idx), .min1_ok(min1_ok), .min2_ok(min2_ok),
      .oor_cnt(oor_cnt), .rd_addr(rd_addr), .rd_data(rd_data));

   huff_sym_histogram #(.CNT_W(4), .BLOCK_LEN(40)) u_sat (
      .clk(clk), .rst(rst), .start(start_s), .data_in(data_in), .data_valid(data_valid),
      .busy(busy_s), .count_done(count_done_s), .scan_done(scan_done_s), .min_valid(min_valid_s),
      .min1_idx(min1_idx_s), .min2_idx(min2_idx_s), .min1_ok(min1_ok_s), .min2_ok(min2_ok_s),
      .oor_cnt(oor_cnt_s), .rd_addr(rd_addr), .rd_data(rd_data_s));

   // counts are a plain histogram; minima are the first two entries of the (count, index) order
   task automatic model(input int cw);
      int b1 = -1, b2 = -1;
      foreach (exp_cnt[i]) exp_cnt[i] = 0;
      exp_oor = 0;
      foreach (syms[k]) begin
         if (syms[k] < NS) exp_cnt[syms[k]] = (exp_cnt[syms[k]] < (1 << cw) - 1) ? exp_cnt[syms[k]] + 1 : exp_cnt[syms[k]];
         else exp_oor++;
      end
      for (int i = 0; i < NS; i++)
         if (exp_cnt[i] > 0 && (b1 < 0 || exp_cnt[i] < exp_cnt[b1])) b1 = i;
      for (int i = 0; i < NS; i++)
         if (i != b1 && exp_cnt[i] > 0 && (b2 < 0 || exp_cnt[i] < exp_cnt[b2])) b2 = i;
      exp_min = {4'(b1 < 0 ? 0 : b1), 4'(b2 < 0 ? 0 : b2), b1 >= 0, b2 >= 0, 1'b1};
   endtask

   task automatic drive_block(input bit sat, input int gap_pct, input int start_at);
      int b = 0;
      cd_n = 0; cd_at = -1; lat = -1;
      @(posedge clk); #1;
      if (sat) start_s = 1'b1; else start = 1'b1;
      data_valid = 1'b1; data_in = 4'd5;
      @(posedge clk); #1;
      start = 1'b0; start_s = 1'b0;
      while (b < syms.size()) begin
         if ($urandom_range(99) < gap_pct) data_valid = 1'b0;
         else begin data_valid = 1'b1; data_in = 4'(syms[b]); b++; end
         start = !sat && b == start_at;
         @(negedge clk);
         if (sat ? count_done_s : count_done) begin cd_n++; cd_at = b; end
         @(posedge clk); #1;
      end
      data_valid = 1'b0; start = 1'b0;
      for (int k = 1; k <= NS + 20; k++) begin
         @(negedge clk);
         if (sat ? scan_done_s : scan_done) begin lat = k; break; end
         @(posedge clk); #1;
      end
      got_min = sat ? {min1_idx_s, min2_idx_s, min1_ok_s, min2_ok_s, min_valid_s}
                    : {min1_idx, min2_idx, min1_ok, min2_ok, min_valid};
      got_oor = sat ? int'(oor_cnt_s) : int'(oor_cnt);
      for (int a = 0; a < NS; a++) begin
         @(posedge clk); #1; rd_addr = 4'(a);
         @(posedge clk); #1; got_cnt[a] = sat ? int'(rd_data_s) : int'(rd_data);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, count_done, scan_done, min_valid, min1_ok, min2_ok, min1_idx, min2_idx, oor_cnt, rd_data} !== '0) begin
         failures++; $display("FAIL reset_outputs got busy=%b cd=%b sd=%b mv=%b ok=%b%b oor=%0d rd=%0d exp all zero",
            busy, count_done, scan_done, min_valid, min1_ok, min2_ok, oor_cnt, rd_data);
      end
   endtask

   task automatic build_ramp;
      syms.delete();
      for (int i = 0; i < NS; i++) repeat (i + 1) syms.push_back(i);
      repeat (201) syms.push_back(9);
   endtask

   task automatic test_ramp(input int gap_pct);
      build_ramp(); model(9);
      drive_block(1'b0, gap_pct, -1);
      checks++; if (cd_n !== 1 || cd_at !== 256) begin failures++; $display("FAIL ramp%0d_count_done got n=%0d beat=%0d exp n=1 beat=256", gap_pct, cd_n, cd_at); end
      checks++; if (lat !== 11) begin failures++; $display("FAIL ramp%0d_scan_latency got=%0d exp=11", gap_pct, lat); end
      checks++; if (got_cnt[9] !== 211) begin failures++; $display("FAIL ramp%0d_cnt9 got=%0d exp=211", gap_pct, got_cnt[9]); end
      foreach (exp_cnt[i]) begin
         checks++; if (got_cnt[i] !== exp_cnt[i]) begin failures++; $display("FAIL ramp%0d_cnt[%0d] got=%0d exp=%0d", gap_pct, i, got_cnt[i], exp_cnt[i]); end
      end
      checks++; if (got_min !== {4'd0, 4'd1, 3'b111}) begin failures++; $display("FAIL ramp%0d_min got=%h exp=%h", gap_pct, got_min, {4'd0, 4'd1, 3'b111}); end
      checks++; if (got_oor !== 0) begin failures++; $display("FAIL ramp%0d_oor got=%0d exp=0", gap_pct, got_oor); end
   endtask

   task automatic test_oor;
      int sum = 0;
      syms.delete();
      repeat (256) syms.push_back($urandom_range(9));
      for (int k = 0; k < 7; k++) syms[k * 36 + $urandom_range(35)] = 10 + $urandom_range(5);
      model(9);
      drive_block(1'b0, 25, -1);
      foreach (got_cnt[i]) sum += got_cnt[i];
      checks++; if (got_oor !== 7) begin failures++; $display("FAIL oor_count got=%0d exp=7", got_oor); end
      checks++; if (sum !== 249) begin failures++; $display("FAIL oor_legal_sum got=%0d exp=249", sum); end
      foreach (exp_cnt[i]) begin
         checks++; if (got_cnt[i] !== exp_cnt[i]) begin failures++; $display("FAIL oor_cnt[%0d] got=%0d exp=%0d", i, got_cnt[i], exp_cnt[i]); end
      end
      checks++; if (got_min !== exp_min) begin failures++; $display("FAIL oor_min got=%h exp=%h", got_min, exp_min); end
   endtask

   task automatic test_saturate;
      syms.delete();
      repeat (40) syms.push_back(3);
      drive_block(1'b1, 0, -1);
      checks++; if (got_cnt[3] !== 15) begin failures++; $display("FAIL sat_cnt3 got=%0d exp=15", got_cnt[3]); end
      checks++; if (got_min !== {4'd3, 4'd0, 3'b101}) begin failures++; $display("FAIL sat_min got=%h exp=%h", got_min, {4'd3, 4'd0, 3'b101}); end
      checks++; if (cd_at !== 40 || lat !== 11) begin failures++; $display("FAIL sat_timing got beat=%0d lat=%0d exp beat=40 lat=11", cd_at, lat); end
   endtask

   task automatic test_tie;
      syms.delete();
      repeat (5) syms.push_back(0);
      repeat (2) syms.push_back(1);
      repeat (2) syms.push_back(2);
      repeat (247) syms.push_back(15);
      drive_block(1'b0, 10, -1);
      checks++; if (got_min !== {4'd1, 4'd2, 3'b111}) begin failures++; $display("FAIL tie_min got=%h exp=%h", got_min, {4'd1, 4'd2, 3'b111}); end
      checks++; if (got_cnt[3] !== 0 || got_oor !== 247) begin failures++; $display("FAIL tie_counts got cnt3=%0d oor=%0d exp cnt3=0 oor=247", got_cnt[3], got_oor); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0; data_valid = 1'b1; data_in = 4'd0;
      repeat (100) @(posedge clk);
      #1 data_valid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
      @(posedge clk); #1 rst = 1'b1; rd_addr = 4'd0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if ({busy, min_valid, rd_data} !== '0) begin failures++; $display("FAIL midrst_after got busy=%b mv=%b rd=%0d exp 0", busy, min_valid, rd_data); end
      syms.delete();
      repeat (256) syms.push_back($urandom_range(9));
      model(9);
      drive_block(1'b0, 30, -1);
      foreach (exp_cnt[i]) begin
         checks++; if (got_cnt[i] !== exp_cnt[i]) begin failures++; $display("FAIL midrst_cnt[%0d] got=%0d exp=%0d", i, got_cnt[i], exp_cnt[i]); end
      end
      checks++; if (got_min !== exp_min) begin failures++; $display("FAIL midrst_min got=%h exp=%h", got_min, exp_min); end
   endtask

   task automatic test_start_ignored;
      syms.delete();
      repeat (256) syms.push_back($urandom_range(9));
      model(9);
      drive_block(1'b0, 20, 128);
      checks++; if (cd_n !== 1 || cd_at !== 256) begin failures++; $display("FAIL midstart_count_done got n=%0d beat=%0d exp n=1 beat=256", cd_n, cd_at); end
      foreach (exp_cnt[i]) begin
         checks++; if (got_cnt[i] !== exp_cnt[i]) begin failures++; $display("FAIL midstart_cnt[%0d] got=%0d exp=%0d", i, got_cnt[i], exp_cnt[i]); end
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 3; r++) begin
         syms.delete();
         repeat (256) syms.push_back($urandom_range(99) < 5 ? $urandom_range(15) : $urandom_range(2 + 3 * r));
         model(9);
         drive_block(1'b0, 40, -1);
         checks++; if (got_min !== exp_min || got_oor !== exp_oor) begin failures++; $display("FAIL rand%0d_min_oor got=%h/%0d exp=%h/%0d", r, got_min, got_oor, exp_min, exp_oor); end
         foreach (exp_cnt[i]) begin
            checks++; if (got_cnt[i] !== exp_cnt[i]) begin failures++; $display("FAIL rand%0d_cnt[%0d] got=%0d exp=%0d", r, i, got_cnt[i], exp_cnt[i]); end
         end
         @(posedge clk); #1 rd_addr = 4'd12;
         @(posedge clk); #1;
         checks++; if (rd_data !== '0) begin failures++; $display("FAIL rand%0d_rd_oob got=%0d exp=0", r, rd_data); end
      end
   endtask

   initial begin
      test_reset();
      test_ramp(0);
      test_ramp(50);
      test_oor();
      test_saturate();
      test_tie();
      test_reset_mid();
      test_start_ignored();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/huff_sym_histogram.md
Name: huff_sym_histogram

Overview:
- Parametrised front end of the Huffman encoder. It counts symbol frequencies over a fixed-length input block.
- After the block ends, it runs a sequential scan that finds the two least-frequent non-zero symbols, which are the first merge pair for tree construction.
- Generalises the fixed 10-symbol / 4-bit / 256-sample counting stage to arbitrary alphabet, sample width and block length.
- Adds valid-qualified input, saturation, out-of-range symbol accounting and a random-access count readout port.

Parameters:
- NUM_SYM, 10, alphabet size; legal symbols are 0..NUM_SYM-1; range 2..256.
- SYM_W, 4, input symbol width; requires 2^SYM_W >= NUM_SYM.
- CNT_W, 9, per-symbol counter width; counters saturate.
- BLOCK_LEN, 256, valid beats per block; range 1..65535.
- IDX_W, $clog2(NUM_SYM), index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; clears counters and opens a block
- data_in  in  SYM_W  input symbol
- data_valid  in  1  data_in qualifier
- busy  out  1  high in COUNT and SCAN
- count_done  out  1  one-cycle pulse on the last accepted beat of a block
- scan_done  out  1  one-cycle pulse when min results become valid
- min_valid  out  1  level, high in DONE
- min1_idx  out  IDX_W  least-frequent non-zero symbol
- min2_idx  out  IDX_W  second least-frequent non-zero symbol
- min1_ok  out  1  min1_idx meaningful (at least 1 non-zero symbol)
- min2_ok  out  1  min2_idx meaningful (at least 2 non-zero symbols)
- oor_cnt  out  16  count of out-of-range symbols in the current block
- rd_addr  in  IDX_W  count readout address
- rd_data  out  CNT_W  count of symbol rd_addr, registered

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All counters, oor_cnt, beat counter, min1_idx, min2_idx, min1_ok, min2_ok, rd_data = 0.
  - busy, count_done, scan_done, min_valid = 0.
  - Reset wins over every other input in the same cycle, including mid-COUNT or mid-SCAN; the partial block is discarded.
- FSM states: IDLE, COUNT, SCAN, DONE.
  - IDLE --start--> COUNT.
  - DONE --start--> COUNT.
  - start in COUNT or SCAN is ignored.
- Start cycle:
  - Counters, oor_cnt, beat counter and min_ok flags clear on the clock edge that registers start.
  - data_valid in the start cycle is ignored.
  - The first beat can be accepted in the following cycle.
- COUNT, each cycle with data_valid=1:
  - If data_in < NUM_SYM: cnt[data_in] += 1, holding at 2^CNT_W-1 once reached.
  - Otherwise: oor_cnt += 1, saturating at 65535.
  - Beat counter increments for every valid beat, in-range or not.
  - On the BLOCK_LEN-th valid beat: that beat is still counted, count_done pulses in the same cycle, and the FSM enters SCAN next cycle.
- data_valid outside COUNT is ignored entirely.
- SCAN:
  - Takes exactly NUM_SYM cycles, index i = 0..NUM_SYM-1, one counter examined per cycle.
  - Zero counts are skipped.
  - Comparison is strict less-than, so on ties the lower index wins.
  - Update rule for candidate c:
    - If c < m1: m2 <= m1, m1 <= c.
    - Else if c < m2: m2 <= c.
  - m1 and m2 start at "empty", i.e. larger than any count.
  - After the final index, the FSM enters DONE.
  - scan_done pulses on the first DONE cycle.
  - min_valid goes high and stays high until the next start or reset.
- Total latency from the last valid beat to scan_done: NUM_SYM+1 cycles.
- min1_ok = (non-zero symbols >= 1); min2_ok = (>= 2). When the matching ok flag is 0, the index output is 0.
- Readout:
  - rd_data <= cnt[rd_addr] every cycle, in any state, so latency is 1 cycle.
  - Values read during COUNT are in-progress counts.
  - rd_addr >= NUM_SYM returns 0.
- Counts are held in DONE until the next start.

Test Plan:
- NUM_SYM=10, BLOCK_LEN=256, symbol i repeated (i+1) times for i=0..9 (55 beats) plus 201 beats of symbol 9 -> counts 1..9 and 211; count_done on beat 256; scan_done 11 cycles later; min1_idx=0, min2_idx=1, both ok; oor_cnt=0.
- Random data_valid gaps (50% duty) with the same data -> identical counts; count_done only on the 256th valid beat.
- Symbols 10..15 injected 7 times in a 256-beat block -> oor_cnt=7; legal counts sum to 249; no counter touched at an out-of-range address.
- CNT_W=4, a block of 40 copies of symbol 3 -> rd_data at addr 3 = 15 (saturated); min1_idx=3, min1_ok=1, min2_ok=0, min2_idx=0.
- Tie case, counts {5,2,2,0,...} -> min1_idx=1, min2_idx=2; symbol 3 (zero count) excluded.
- rst asserted at beat 100, then start, then a full block -> results reflect only the new block; start pulsed mid-COUNT -> ignored, block completes at the original beat count.
